test_result_monitor: RTL

- Synthesizable pass/fail monitor that sits directly downstream of the core.
- Observes the core's program counter and register x3 (gp) while the core runs a riscv-tests program.
- Decides pass, fail, timeout or stall, and latches the verdict on sticky status outputs.
- Replaces ad-hoc polling in benches; the same logic can drive LEDs or a status register on hardware.

---
 rtl/test_result_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/test_result_monitor.sv
// Pass/fail monitor for riscv-tests programs: watches pc and gp (x3) and
// latches a sticky pass, fail, timeout or stall verdict.
module test_result_monitor #(
    parameter logic [31:0] PASS_PC        = 32'h0000_0044,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned STALL_LIMIT    = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      pc,
    input  logic [31:0]      gp,
    output logic             done,
    output logic             passed,
    output logic             failed,
    output logic             timed_out,
    output logic             stalled,
    output logic [30:0]      fail_testnum,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       status,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic             passed_q, passed_d;
    logic             failed_q, failed_d;
    logic             timed_out_q, timed_out_d;
    logic             stalled_q, stalled_d;
    logic [30:0]      fail_testnum_q, fail_testnum_d;
    logic [1:0]       status_q, status_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cycle_q        <= '0;
            stall_q        <= '0;
            last_pc_q      <= '0;
            passed_q       <= 1'b0;
            failed_q       <= 1'b0;
            timed_out_q    <= 1'b0;
            stalled_q      <= 1'b0;
            fail_testnum_q <= '0;
            status_q       <= 2'b00;
        end else begin
            state_q        <= state_d;
            cycle_q        <= cycle_d;
            stall_q        <= stall_d;
            last_pc_q      <= last_pc_d;
            passed_q       <= passed_d;
            failed_q       <= failed_d;
            timed_out_q    <= timed_out_d;
            stalled_q      <= stalled_d;
            fail_testnum_q <= fail_testnum_d;
            status_q       <= status_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cycle_d        = cycle_q;
        stall_d        = stall_q;
        last_pc_d      = last_pc_q;
        passed_d       = passed_q;
        failed_d       = failed_q;
        timed_out_d    = timed_out_q;
        stalled_d      = stalled_q;
        fail_testnum_d = fail_testnum_q;
        status_d       = status_q;

        case (state_q)
            S_RUN: begin
                // Checks are ordered by priority: pass/fail, then timeout, then stall.
                if (pc == PASS_PC) begin
                    state_d = S_DONE;
                    if (gp == 32'h1) begin
                        passed_d = 1'b1;
                        status_d = 2'b01;
                    end else begin
                        failed_d       = 1'b1;
                        status_d       = 2'b10;
                        fail_testnum_d = gp[31:1];
                    end
                end else if (cycle_q == TIMEOUT_LAST) begin
                    state_d     = S_DONE;
                    timed_out_d = 1'b1;
                    status_d    = 2'b11;
                end else if ((stall_q == STALL_LAST) && (pc == last_pc_q)) begin
                    state_d   = S_DONE;
                    stalled_d = 1'b1;
                    status_d  = 2'b11;
                end else begin
                    cycle_d   = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + 1'b1;
                    stall_d   = (pc == last_pc_q) ? stall_q + 1'b1 : '0;
                    last_pc_d = pc;
                end
            end
            default: begin
                // IDLE and DONE only look at start, so an unknown pc/gp cannot leak out.
                if (start) begin
                    state_d        = S_RUN;
                    cycle_d        = '0;
                    stall_d        = '0;
                    last_pc_d      = pc;
                    passed_d       = 1'b0;
                    failed_d       = 1'b0;
                    timed_out_d    = 1'b0;
                    stalled_d      = 1'b0;
                    fail_testnum_d = '0;
                    status_d       = 2'b00;
                end
            end
        endcase
    end

    assign done         = (state_q == S_DONE);
    assign passed       = passed_q;
    assign failed       = failed_q;
    assign timed_out    = timed_out_q;
    assign stalled      = stalled_q;
    assign fail_testnum = fail_testnum_q;
    assign cycle_count  = cycle_q;
    assign status       = status_q;
    assign state_dbg    = state_q;

endmodule
